monitor_varredura_7seg: RTL and testbench

// - Receive end of the 4-digit multiplexed 7-segment display bus that the filling/sealing controller drives.
// - Samples the active-low segment and anode lines and rebuilds the 4 BCD digits of each scan frame.
// - Publishes the garrafas (bottle) value and the rolhas (cork) value as binary once they are stable.
// - Used by board self-test and by the bench as a scoreboard probe.

---
 rtl/pkg_display7seg.sv | 29 ++
 rtl/decodificador_7seg_bcd.sv | 26 ++
 rtl/monitor_varredura_7seg.sv | 227 ++++++++++++++++++++++
 tb/tb_monitor_varredura_7seg.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pkg_display7seg.sv
// Shared types and constants for the 7-segment scan monitor: FSM states,
// active-high A..G digit patterns, anode indices and the BCD pair helper.
package pkg_display7seg;

  typedef enum logic [1:0] {
    S_HUNT = 2'd0,
    S_CAP  = 2'd1,
    S_CMP  = 2'd2
  } state_t;

  // Bit 6 = segment A ... bit 0 = segment G, active-high
  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
    7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011
  };
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  localparam logic [1:0] IDX_DZ_GARRAFAS = 2'd0;
  localparam logic [1:0] IDX_UN_GARRAFAS = 2'd1;
  localparam logic [1:0] IDX_DZ_ROLHAS   = 2'd2;
  localparam logic [1:0] IDX_UN_ROLHAS   = 2'd3;

  // tens*10 + units built from shifts: tens*2 + tens*8 + units
  function automatic logic [6:0] bcd_pair_to_bin(input logic [3:0] tens,
                                                 input logic [3:0] units);
    return 7'({tens, 1'b0}) + 7'({tens, 3'b000}) + 7'(units);
  endfunction

endpackage

// File: rtl/decodificador_7seg_bcd.sv
// Combinational lookup of an active-high A..G pattern into a BCD digit.
// A blanked display reads as 0; any unknown pattern drops valid.
module decodificador_7seg_bcd
  import pkg_display7seg::*;
(
  input  logic [6:0] seg,
  output logic       valid,
  output logic [3:0] bcd
);

  always_comb begin
    valid = 1'b0;
    bcd   = 4'd0;
    if (seg == SEG_BLANK) begin
      valid = 1'b1;
    end else begin
      for (int i = 0; i < 10; i++) begin
        if (seg == SEG_DIGIT[i]) begin
          valid = 1'b1;
          bcd   = 4'(i);
        end
      end
    end
  end

endmodule

// File: rtl/monitor_varredura_7seg.sv
// Receive-side monitor for the 4-digit multiplexed 7-segment bus: rebuilds
// each scan frame and publishes garrafas/rolhas once stable. Optional
// scan watchdog enabled by defining SCAN_WATCHDOG_EN.
module monitor_varredura_7seg
  import pkg_display7seg::*;
#(
  parameter int SETTLE_CYCLES  = 2,
  parameter int STABLE_FRAMES  = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [7:0] Nout_7seg,
  input  logic [3:0] Nac_7segmentos,
  output logic [6:0] garrafas_val,
  output logic [6:0] rolhas_val,
  output logic       frame_valid,
  output logic       frame_stb,
  output logic       err_seg,
  output logic       err_anode,
  output logic       err_timeout
);

  localparam logic [3:0] SETTLE_LIM = 4'(SETTLE_CYCLES);
  localparam logic [2:0] STABLE_LIM = 3'(STABLE_FRAMES);

  logic [6:0] seg_s1_q, seg_s2_q;
  logic [3:0] an_s1_q, an_s2_q, an_prev_q;
  logic [3:0] settle_q, settle_d;
  state_t     state_q, state_d;
  logic [1:0] exp_q, exp_d;
  logic [15:0] cur_q, cur_d, prev_q, prev_d;
  logic       prev_ok_q, prev_ok_d;
  logic [2:0] stable_q, stable_d;
  logic [6:0] garr_q, garr_d, rolh_q, rolh_d;
  logic       fv_q, fv_d, stb_q, stb_d;
  logic       err_seg_q, err_seg_d, err_an_q, err_an_d;

  logic       dp_unused;
  logic       anode_chg, sample, take, seg_ok, onehot;
  logic [3:0] an_ah, bcd;
  logic [1:0] an_idx;
  logic [6:0] g_val, r_val;

  assign dp_unused = Nout_7seg[0];

  decodificador_7seg_bcd u_dec (
    .seg   (~seg_s2_q),
    .valid (seg_ok),
    .bcd   (bcd)
  );

  assign an_ah     = ~an_s2_q;
  assign onehot    = $onehot(an_ah);
  assign anode_chg = (an_s2_q != an_prev_q);
  assign g_val     = bcd_pair_to_bin(cur_q[3:0], cur_q[7:4]);
  assign r_val     = bcd_pair_to_bin(cur_q[11:8], cur_q[15:12]);

  always_comb begin
    an_idx = IDX_DZ_GARRAFAS;
    case (an_ah)
      4'b0010: an_idx = IDX_UN_GARRAFAS;
      4'b0100: an_idx = IDX_DZ_ROLHAS;
      4'b1000: an_idx = IDX_UN_ROLHAS;
      default: an_idx = IDX_DZ_GARRAFAS;
    endcase
  end

  // One sample per dwell: the cycle the settle count first hits its limit
  always_comb begin
    if (anode_chg)                    settle_d = 4'd0;
    else if (settle_q == SETTLE_LIM)  settle_d = settle_q;
    else                              settle_d = settle_q + 4'd1;
    sample = !anode_chg && (settle_d == SETTLE_LIM) && (settle_q != SETTLE_LIM);
    take   = sample && (an_s2_q != 4'hF);
  end

`ifdef SCAN_WATCHDOG_EN
  localparam logic [15:0] WD_LIM = 16'(TIMEOUT_CYCLES);
  logic [15:0] wd_q, wd_d;
  logic        err_to_q, err_to_d;
`endif

  always_comb begin
    state_d    = state_q;
    exp_d      = exp_q;
    cur_d      = cur_q;
    prev_d     = prev_q;
    prev_ok_d  = prev_ok_q;
    stable_d   = stable_q;
    garr_d     = garr_q;
    rolh_d     = rolh_q;
    fv_d       = fv_q;
    stb_d      = 1'b0;
    err_seg_d  = err_seg_q;
    err_an_d   = err_an_q;

    case (state_q)
      S_HUNT: begin
        if (take) begin
          if (!seg_ok) begin
            err_seg_d = 1'b1;
          end else if (!onehot) begin
            err_an_d = 1'b1;
          end else if (an_idx == IDX_DZ_GARRAFAS) begin
            cur_d[3:0] = bcd;
            exp_d      = IDX_UN_GARRAFAS;
            state_d    = S_CAP;
          end
        end
      end
      S_CAP: begin
        if (take) begin
          if (!seg_ok) begin
            err_seg_d = 1'b1;
            state_d   = S_HUNT;
          end else if (!onehot || (an_idx != exp_q)) begin
            err_an_d = 1'b1;
            state_d  = S_HUNT;
          end else begin
            cur_d[{exp_q, 2'b00} +: 4] = bcd;
            exp_d = exp_q + 2'd1;
            if (exp_q == IDX_UN_ROLHAS) state_d = S_CMP;
          end
        end
      end
      S_CMP: begin
        if (prev_ok_q && (cur_q == prev_q))
          stable_d = (stable_q == STABLE_LIM) ? stable_q : stable_q + 3'd1;
        else
          stable_d = 3'd1;
        prev_d    = cur_q;
        prev_ok_d = 1'b1;
        if ((stable_d == STABLE_LIM) &&
            (!fv_q || (g_val != garr_q) || (r_val != rolh_q))) begin
          garr_d = g_val;
          rolh_d = r_val;
          fv_d   = 1'b1;
          stb_d  = 1'b1;
        end
        // The sample after digit 3 is digit 0 of the following frame
        state_d = S_CAP;
        exp_d   = IDX_DZ_GARRAFAS;
      end
      default: state_d = S_HUNT;
    endcase

`ifdef SCAN_WATCHDOG_EN
    err_to_d = err_to_q;
    if (anode_chg)          wd_d = 16'd0;
    else if (wd_q == WD_LIM) wd_d = wd_q;
    else                    wd_d = wd_q + 16'd1;
    if ((wd_d == WD_LIM) && (wd_q != WD_LIM)) begin
      err_to_d = 1'b1;
      fv_d     = 1'b0;
      state_d  = S_HUNT;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      seg_s1_q  <= 7'h7F;
      seg_s2_q  <= 7'h7F;
      an_s1_q   <= 4'hF;
      an_s2_q   <= 4'hF;
      an_prev_q <= 4'hF;
      settle_q  <= 4'd0;
      state_q   <= S_HUNT;
      exp_q     <= IDX_DZ_GARRAFAS;
      prev_ok_q <= 1'b0;
      stable_q  <= 3'd0;
      garr_q    <= 7'd0;
      rolh_q    <= 7'd0;
      fv_q      <= 1'b0;
      stb_q     <= 1'b0;
      err_seg_q <= 1'b0;
      err_an_q  <= 1'b0;
    end else begin
      seg_s1_q  <= Nout_7seg[7:1];
      seg_s2_q  <= seg_s1_q;
      an_s1_q   <= Nac_7segmentos;
      an_s2_q   <= an_s1_q;
      an_prev_q <= an_s2_q;
      settle_q  <= settle_d;
      state_q   <= state_d;
      exp_q     <= exp_d;
      prev_ok_q <= prev_ok_d;
      stable_q  <= stable_d;
      garr_q    <= garr_d;
      rolh_q    <= rolh_d;
      fv_q      <= fv_d;
      stb_q     <= stb_d;
      err_seg_q <= err_seg_d;
      err_an_q  <= err_an_d;
    end
  end

  // Frame digit storage is guarded by state/prev_ok, so it needs no reset
  always_ff @(posedge clk) begin
    cur_q  <= cur_d;
    prev_q <= prev_d;
  end

`ifdef SCAN_WATCHDOG_EN
  always_ff @(posedge clk) begin
    if (!clr) begin
      wd_q     <= 16'd0;
      err_to_q <= 1'b0;
    end else begin
      wd_q     <= wd_d;
      err_to_q <= err_to_d;
    end
  end
  assign err_timeout = err_to_q;
`else
  assign err_timeout = 1'b0;
`endif

  assign garrafas_val = garr_q;
  assign rolhas_val   = rolh_q;
  assign frame_valid  = fv_q;
  assign frame_stb    = stb_q;
  assign err_seg      = err_seg_q;
  assign err_anode    = err_an_q;

endmodule

// File: tb/tb_monitor_varredura_7seg.sv
// Randomised bench for monitor_varredura_7seg with a frame-level reference model.
module tb_monitor_varredura_7seg;

  localparam int STABLE = 2;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] Nout_7seg = 8'hFF;
  logic [3:0] Nac_7segmentos = 4'hF;
  logic [6:0] garrafas_val, rolhas_val;
  logic       frame_valid, frame_stb, err_seg, err_anode, err_timeout;

  monitor_varredura_7seg #(
    .SETTLE_CYCLES (2),
    .STABLE_FRAMES (STABLE),
    .TIMEOUT_CYCLES(1024)
  ) dut (
    .clk           (clk),
    .clr           (clr),
    .Nout_7seg     (Nout_7seg),
    .Nac_7segmentos(Nac_7segmentos),
    .garrafas_val  (garrafas_val),
    .rolhas_val    (rolhas_val),
    .frame_valid   (frame_valid),
    .frame_stb     (frame_stb),
    .err_seg       (err_seg),
    .err_anode     (err_anode),
    .err_timeout   (err_timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int stb_seen = 0;

  always @(negedge clk) if (frame_stb === 1'b1) stb_seen++;

  logic [6:0] seg_tab [0:9] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
    7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011
  };

  // Frame to send (10 = blanked digit) and the frame-level model state
  int fr [4];
  int m_prev [4];
  bit m_prev_ok;
  int m_stable;
  int m_g, m_r, m_stb;
  bit m_valid;
  bit e_seg, e_an;

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [6:0] seg_of(input int d);
    return (d < 10) ? seg_tab[d] : 7'b0000000;
  endfunction

  function automatic int dval(input int d);
    return (d > 9) ? 0 : d;
  endfunction

  task automatic drive_digit(input int idx, input logic [6:0] seg_ah, input int dwell);
    logic [3:0] onehot;
    onehot = 4'b0001 << idx;
    Nac_7segmentos = ~onehot;
    Nout_7seg = {~seg_ah, 1'($urandom_range(0, 1))};
    cycles(dwell);
  endtask

  function automatic void model_reset();
    m_prev_ok = 1'b0;
    m_stable = 0;
    m_valid = 1'b0;
    m_g = 0;
    m_r = 0;
  endfunction

  function automatic void model_frame();
    int fv [4];
    bit eq;
    int g, r;
    eq = 1'b1;
    for (int i = 0; i < 4; i++) begin
      fv[i] = dval(fr[i]);
      if (fv[i] != m_prev[i]) eq = 1'b0;
    end
    if (m_prev_ok && eq) m_stable = (m_stable < STABLE) ? m_stable + 1 : STABLE;
    else m_stable = 1;
    for (int i = 0; i < 4; i++) m_prev[i] = fv[i];
    m_prev_ok = 1'b1;
    g = fv[0] * 10 + fv[1];
    r = fv[2] * 10 + fv[3];
    if (m_stable == STABLE && (!m_valid || g != m_g || r != m_r)) begin
      m_g = g;
      m_r = r;
      m_valid = 1'b1;
      m_stb++;
    end
  endfunction

  task automatic send_frame();
    for (int i = 0; i < 4; i++) drive_digit(i, seg_of(fr[i]), $urandom_range(5, 8));
    cycles(4);
    model_frame();
  endtask

  task automatic random_frame();
    for (int i = 0; i < 4; i++) fr[i] = $urandom_range(0, 10);
  endtask

  task automatic test_reset();
    clr = 1'b0;
    cycles(3);
    checks += 7;
    if (garrafas_val !== 7'd0) begin failures++; $display("FAIL reset_garrafas got=%0d exp=0", garrafas_val); end
    if (rolhas_val !== 7'd0) begin failures++; $display("FAIL reset_rolhas got=%0d exp=0", rolhas_val); end
    if (frame_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", frame_valid); end
    if (frame_stb !== 1'b0) begin failures++; $display("FAIL reset_stb got=%b exp=0", frame_stb); end
    if (err_seg !== 1'b0) begin failures++; $display("FAIL reset_err_seg got=%b exp=0", err_seg); end
    if (err_anode !== 1'b0) begin failures++; $display("FAIL reset_err_anode got=%b exp=0", err_anode); end
    if (err_timeout !== 1'b0) begin failures++; $display("FAIL reset_err_timeout got=%b exp=0", err_timeout); end
    clr = 1'b1;
    model_reset();
    cycles(3);
  endtask

  task automatic test_clean_scan();
    int stb0;
    stb0 = stb_seen;
    fr = '{1, 2, 3, 4};
    send_frame();
    checks++;
    if (frame_valid !== 1'b0) begin failures++; $display("FAIL clean_valid_early got=%b exp=0", frame_valid); end
    send_frame();
    checks += 6;
    if (garrafas_val !== 7'd12) begin failures++; $display("FAIL clean_garrafas got=%0d exp=12", garrafas_val); end
    if (rolhas_val !== 7'd34) begin failures++; $display("FAIL clean_rolhas got=%0d exp=34", rolhas_val); end
    if (stb_seen - stb0 != 1) begin failures++; $display("FAIL clean_stb_count got=%0d exp=1", stb_seen - stb0); end
    if (frame_valid !== 1'b1) begin failures++; $display("FAIL clean_valid got=%b exp=1", frame_valid); end
    if (err_seg !== 1'b0) begin failures++; $display("FAIL clean_err_seg got=%b exp=0", err_seg); end
    if (err_anode !== 1'b0) begin failures++; $display("FAIL clean_err_anode got=%b exp=0", err_anode); end
  endtask

  task automatic test_glitch_frame();
    int stb0;
    stb0 = stb_seen;
    fr = '{1, 2, 5, 4};
    send_frame();
    fr = '{1, 2, 3, 4};
    send_frame();
    send_frame();
    checks += 3;
    if (garrafas_val !== 7'd12) begin failures++; $display("FAIL glitch_garrafas got=%0d exp=12", garrafas_val); end
    if (rolhas_val !== 7'd34) begin failures++; $display("FAIL glitch_rolhas got=%0d exp=34", rolhas_val); end
    if (stb_seen != stb0) begin failures++; $display("FAIL glitch_stb got=%0d exp=%0d", stb_seen, stb0); end
  endtask

  task automatic test_bad_order();
    drive_digit(0, seg_of(7), 6);
    drive_digit(2, seg_of(8), 6);
    drive_digit(1, seg_of(9), 6);
    drive_digit(3, seg_of(6), 6);
    cycles(4);
    e_an = 1'b1;
    checks += 4;
    if (err_anode !== 1'b1) begin failures++; $display("FAIL order_err_anode got=%b exp=1", err_anode); end
    if (garrafas_val !== 7'(m_g)) begin failures++; $display("FAIL order_garrafas_kept got=%0d exp=%0d", garrafas_val, m_g); end
    if (rolhas_val !== 7'(m_r)) begin failures++; $display("FAIL order_rolhas_kept got=%0d exp=%0d", rolhas_val, m_r); end
    if (stb_seen != m_stb) begin failures++; $display("FAIL order_stb got=%0d exp=%0d", stb_seen, m_stb); end
    fr = '{5, 6, 7, 8};
    send_frame();
    send_frame();
    checks += 3;
    if (garrafas_val !== 7'(m_g)) begin failures++; $display("FAIL order_resync_garrafas got=%0d exp=%0d", garrafas_val, m_g); end
    if (rolhas_val !== 7'(m_r)) begin failures++; $display("FAIL order_resync_rolhas got=%0d exp=%0d", rolhas_val, m_r); end
    if (stb_seen != m_stb) begin failures++; $display("FAIL order_resync_stb got=%0d exp=%0d", stb_seen, m_stb); end
  endtask

  task automatic test_bad_segment();
    drive_digit(0, seg_of(3), 6);
    drive_digit(1, 7'b0000001, 6);
    drive_digit(2, seg_of(4), 6);
    drive_digit(3, seg_of(5), 6);
    cycles(4);
    e_seg = 1'b1;
    checks += 3;
    if (err_seg !== 1'b1) begin failures++; $display("FAIL seg_err_seg got=%b exp=1", err_seg); end
    if (err_anode !== e_an) begin failures++; $display("FAIL seg_err_anode got=%b exp=%b", err_anode, e_an); end
    if (garrafas_val !== 7'(m_g)) begin failures++; $display("FAIL seg_garrafas_kept got=%0d exp=%0d", garrafas_val, m_g); end
    fr = '{9, 0, 10, 1};
    send_frame();
    send_frame();
    checks += 3;
    if (garrafas_val !== 7'd90) begin failures++; $display("FAIL seg_recover_garrafas got=%0d exp=90", garrafas_val); end
    if (rolhas_val !== 7'd1) begin failures++; $display("FAIL seg_recover_rolhas got=%0d exp=1", rolhas_val); end
    if (stb_seen != m_stb) begin failures++; $display("FAIL seg_recover_stb got=%0d exp=%0d", stb_seen, m_stb); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 16; n++) begin
      if (n < 2) fr = '{9, 9, 9, 9};
      else if ($urandom_range(0, 1) == 0) random_frame();
      send_frame();
      checks += 5;
      if (garrafas_val !== 7'(m_g)) begin failures++; $display("FAIL rand%0d_garrafas got=%0d exp=%0d", n, garrafas_val, m_g); end
      if (rolhas_val !== 7'(m_r)) begin failures++; $display("FAIL rand%0d_rolhas got=%0d exp=%0d", n, rolhas_val, m_r); end
      if (frame_valid !== m_valid) begin failures++; $display("FAIL rand%0d_valid got=%b exp=%b", n, frame_valid, m_valid); end
      if (stb_seen != m_stb) begin failures++; $display("FAIL rand%0d_stb got=%0d exp=%0d", n, stb_seen, m_stb); end
      if ({err_seg, err_anode} !== {e_seg, e_an}) begin failures++; $display("FAIL rand%0d_errs got=%b%b exp=%b%b", n, err_seg, err_anode, e_seg, e_an); end
    end
  endtask

  task automatic test_reset_mid_frame();
    random_frame();
    drive_digit(0, seg_of(fr[0]), 6);
    drive_digit(1, seg_of(fr[1]), 6);
    drive_digit(2, seg_of(fr[2]), 2);
    clr = 1'b0;
    @(posedge clk);
    #1;
    checks += 6;
    if (garrafas_val !== 7'd0) begin failures++; $display("FAIL midrst_garrafas got=%0d exp=0", garrafas_val); end
    if (rolhas_val !== 7'd0) begin failures++; $display("FAIL midrst_rolhas got=%0d exp=0", rolhas_val); end
    if (frame_valid !== 1'b0) begin failures++; $display("FAIL midrst_valid got=%b exp=0", frame_valid); end
    if (frame_stb !== 1'b0) begin failures++; $display("FAIL midrst_stb got=%b exp=0", frame_stb); end
    if (err_seg !== 1'b0) begin failures++; $display("FAIL midrst_err_seg got=%b exp=0", err_seg); end
    if (err_anode !== 1'b0) begin failures++; $display("FAIL midrst_err_anode got=%b exp=0", err_anode); end
    @(negedge clk);
    clr = 1'b1;
    Nac_7segmentos = 4'hF;
    model_reset();
    e_seg = 1'b0;
    e_an = 1'b0;
    cycles(3);
    fr = '{4, 2, 0, 7};
    send_frame();
    checks++;
    if (frame_valid !== 1'b0) begin failures++; $display("FAIL midrst_fresh1_valid got=%b exp=0", frame_valid); end
    send_frame();
    checks += 3;
    if (frame_valid !== 1'b1) begin failures++; $display("FAIL midrst_fresh2_valid got=%b exp=1", frame_valid); end
    if (garrafas_val !== 7'd42) begin failures++; $display("FAIL midrst_garrafas_pub got=%0d exp=42", garrafas_val); end
    if (rolhas_val !== 7'd7) begin failures++; $display("FAIL midrst_rolhas_pub got=%0d exp=7", rolhas_val); end
  endtask

  task automatic test_watchdog();
`ifdef SCAN_WATCHDOG_EN
    drive_digit(1, seg_of(3), 1100);
    checks += 2;
    if (err_timeout !== 1'b1) begin failures++; $display("FAIL wd_err_timeout got=%b exp=1", err_timeout); end
    if (frame_valid !== 1'b0) begin failures++; $display("FAIL wd_valid got=%b exp=0", frame_valid); end
`else
    drive_digit(1, seg_of(3), 200);
    checks += 2;
    if (err_timeout !== 1'b0) begin failures++; $display("FAIL nowd_err_timeout got=%b exp=0", err_timeout); end
    if (frame_valid !== 1'b1) begin failures++; $display("FAIL nowd_valid_kept got=%b exp=1", frame_valid); end
`endif
  endtask

  initial begin
    for (int i = 0; i < 4; i++) m_prev[i] = 0;
    m_stb = 0;
    e_seg = 1'b0;
    e_an = 1'b0;
    model_reset();
    test_reset();
    test_clean_scan();
    test_glitch_frame();
    test_bad_order();
    test_bad_segment();
    test_random();
    test_reset_mid_frame();
    test_watchdog();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
